// File: rtl/agu_ndim.sv
// N-dimensional address generation unit: nested-loop address sequencer with
// valid/ready output. Optional level-0 wrap indicator under AGU_ZIGZAG_EN.
module agu_ndim #(
  parameter int BWADDR   = 21,
  parameter int BWLENGTH = 8,
  parameter int NDIM     = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         start,
  input  logic                         cont,
  input  logic [BWADDR-1:0]            base,
  input  logic [NDIM*BWLENGTH-1:0]     lens,
  input  logic [(NDIM+1)*BWADDR-1:0]   jumps,
  input  logic                         addr_ready,
  output logic [BWADDR-1:0]            addr_out,
  output logic                         addr_valid,
  output logic                         busy,
  output logic                         done,
  output logic                         zigzag_step
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                            state_q, state_d;
  logic                              cont_q, cont_d;
  logic [NDIM-1:0][BWLENGTH-1:0]     lens_q, lens_d;
  logic [NDIM-1:0][BWLENGTH-1:0]     cnt_q, cnt_d, cnt_step;
  logic [NDIM:0][BWADDR-1:0]         jumps_q, jumps_d;
  logic [BWADDR-1:0]                 addr_q, addr_d, step;
  logic                              valid_q, valid_d;
  logic                              done_q, done_d;
  logic                              fire, any_nz;

  assign fire = valid_q && addr_ready;

  // Lowest nonzero level steps; levels below it reload. With no nonzero
  // level every counter reloads and the wrap jump is selected.
  always_comb begin
    cnt_step = cnt_q;
    step     = jumps_q[NDIM];
    any_nz   = 1'b0;
    for (int unsigned k = 0; k < NDIM; k++) begin
      if (!any_nz) begin
        if (cnt_q[k] != '0) begin
          any_nz      = 1'b1;
          cnt_step[k] = cnt_q[k] - BWLENGTH'(1);
          step        = jumps_q[k];
        end else begin
          cnt_step[k] = lens_q[k];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cont_d  = cont_q;
    lens_d  = lens_q;
    jumps_d = jumps_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    if (clr) begin
      state_d = IDLE;
      valid_d = 1'b0;
      addr_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cont_d  = cont;
            lens_d  = lens;
            jumps_d = jumps;
            cnt_d   = lens;
            addr_d  = base;
            valid_d = 1'b1;
            state_d = RUN;
          end
        end
        RUN: begin
          if (fire) begin
            if (any_nz || cont_q) begin
              addr_d = addr_q + step;
              cnt_d  = cnt_step;
            end else begin
              valid_d = 1'b0;
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cont_q  <= 1'b0;
      lens_q  <= '0;
      jumps_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cont_q  <= cont_d;
      lens_q  <= lens_d;
      jumps_q <= jumps_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign addr_out   = addr_q;
  assign addr_valid = valid_q;
  assign done       = done_q;
  assign busy       = (state_q == RUN);

`ifdef AGU_ZIGZAG_EN
  logic upper_nz;

  always_comb begin
    upper_nz = cont_q;
    for (int unsigned k = 1; k < NDIM; k++) begin
      if (cnt_q[k] != '0) upper_nz = 1'b1;
    end
  end

  assign zigzag_step = fire && (cnt_q[0] == '0) && upper_nz;
`else
  assign zigzag_step = 1'b0;
`endif

endmodule

// File: tb/tb_agu_ndim.sv
// Self-checking bench for agu_ndim: scoreboard of expected addresses and
// zigzag flags, one task per scenario.
module tb_agu_ndim;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic [20:0] base = '0;
  logic [23:0] lens = '0;
  logic [83:0] jumps = '0;
  logic        addr_ready = 1'b1;
  logic [20:0] addr_out;
  logic        addr_valid, busy, done, zigzag_step;

  int errors = 0;
  int checks = 0;

  logic [20:0] sb[$];
  bit          zq[$];

  logic [20:0] mb;
  logic [7:0]  ml[3];
  logic [20:0] mj[4];

  agu_ndim #(.BWADDR(21), .BWLENGTH(8), .NDIM(3)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .cont(cont),
    .base(base), .lens(lens), .jumps(jumps), .addr_ready(addr_ready),
    .addr_out(addr_out), .addr_valid(addr_valid), .busy(busy), .done(done),
    .zigzag_step(zigzag_step)
  );

  always #5 clk = ~clk;

  function automatic bit zexp(input bit z);
`ifdef AGU_ZIGZAG_EN
    return z;
`else
    return 1'b0;
`endif
  endfunction

  task automatic load(input logic [20:0] b, input logic [7:0] l0, l1, l2,
                      input logic [20:0] j0, j1, j2, j3);
    mb = b; ml[0] = l0; ml[1] = l1; ml[2] = l2;
    mj[0] = j0; mj[1] = j1; mj[2] = j2; mj[3] = j3;
    base  = b;
    lens  = {l2, l1, l0};
    jumps = {j3, j2, j1, j0};
  endtask

  // Config is scrambled after the start cycle to show it was latched.
  task automatic do_start(input bit c);
    @(negedge clk);
    start = 1'b1;
    cont  = c;
    @(negedge clk);
    start = 1'b0;
    cont  = ~c;
    base  = 21'($urandom);
    lens  = 24'($urandom);
    jumps = {21'($urandom), 21'($urandom), 21'($urandom), 21'($urandom)};
  endtask

  task automatic model(input bit c, input int reps);
    logic [20:0] ad;
    ad = mb;
    for (int r = 0; r < reps; r++) begin
      for (int a2 = 0; a2 <= int'(ml[2]); a2++) begin
        for (int a1 = 0; a1 <= int'(ml[1]); a1++) begin
          for (int a0 = 0; a0 <= int'(ml[0]); a0++) begin
            sb.push_back(ad);
            zq.push_back(zexp(a0 == int'(ml[0]) &&
                              (!(a1 == int'(ml[1]) && a2 == int'(ml[2])) || c)));
            if (a0 < int'(ml[0])) ad = ad + mj[0];
          end
          if (a1 < int'(ml[1])) ad = ad + mj[1];
        end
        if (a2 < int'(ml[2])) ad = ad + mj[2];
      end
      ad = ad + mj[3];
    end
  endtask

  // Consumes the scoreboard with ready high; addresses must be back to back.
  task automatic drain(input bit expect_done);
    logic [20:0] exp_a;
    bit          exp_z;
    addr_ready = 1'b1;
    while (sb.size() > 0) begin
      checks++;
      if (addr_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream_valid: addr_valid=%b required 1 (%0d pending)", addr_valid, sb.size());
        sb.delete();
        zq.delete();
        break;
      end
      exp_a = sb.pop_front();
      exp_z = zq.pop_front();
      checks++;
      if (addr_out !== exp_a) begin
        errors++;
        $display("FAIL stream_addr: got %0d required %0d", addr_out, exp_a);
      end
      checks++;
      if (zigzag_step !== exp_z) begin
        errors++;
        $display("FAIL zigzag: got %b required %b at addr %0d", zigzag_step, exp_z, exp_a);
      end
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stream_flags: done=%b busy=%b required 0/1", done, busy);
      end
      @(negedge clk);
    end
    if (expect_done) begin
      checks++;
      if (done !== 1'b1 || addr_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse: done=%b valid=%b busy=%b required 1/0/0", done, addr_valid, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || addr_valid !== 1'b0) begin
        errors++;
        $display("FAIL done_width: done=%b valid=%b required 0/0", done, addr_valid);
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (addr_out !== '0 || addr_valid !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || zigzag_step !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: addr=%0d valid=%b busy=%b done=%b zz=%b required all 0",
               addr_out, addr_valid, busy, done, zigzag_step);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic std_cfg();
    load(21'd100, 8'd1, 8'd1, 8'd0, 21'd1, 21'd10, 21'd50, 21'd1000);
  endtask

  task automatic test_oneshot();
    std_cfg();
    sb.push_back(21'd100); zq.push_back(1'b0);
    sb.push_back(21'd101); zq.push_back(zexp(1'b1));
    sb.push_back(21'd111); zq.push_back(1'b0);
    sb.push_back(21'd112); zq.push_back(1'b0);
    do_start(1'b0);
    drain(1'b1);
  endtask

  task automatic test_continuous();
    std_cfg();
    model(1'b1, 2);
    do_start(1'b1);
    drain(1'b0);
    checks++;
    if (addr_valid !== 1'b1 || done !== 1'b0 || addr_out !== 21'd2124) begin
      errors++;
      $display("FAIL cont_wrap: valid=%b done=%b addr=%0d required 1/0/2124", addr_valid, done, addr_out);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (addr_valid !== 1'b0 || addr_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL cont_clr: valid=%b addr=%0d busy=%b done=%b required 0/0/0/0",
               addr_valid, addr_out, busy, done);
    end
  endtask

  task automatic test_backpressure();
    std_cfg();
    sb.push_back(21'd100); zq.push_back(1'b0);
    do_start(1'b0);
    drain(1'b0);
    addr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (addr_out !== 21'd101 || addr_valid !== 1'b1 || zigzag_step !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d addr=%0d valid=%b zz=%b required 101/1/0",
                 i, addr_out, addr_valid, zigzag_step);
      end
    end
    sb.push_back(21'd101); zq.push_back(zexp(1'b1));
    sb.push_back(21'd111); zq.push_back(1'b0);
    sb.push_back(21'd112); zq.push_back(1'b0);
    drain(1'b1);
  endtask

  task automatic test_clr();
    std_cfg();
    sb.push_back(21'd100); zq.push_back(1'b0);
    sb.push_back(21'd101); zq.push_back(zexp(1'b1));
    do_start(1'b0);
    drain(1'b0);
    std_cfg();
    clr   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clr   = 1'b0;
    start = 1'b0;
    checks++;
    if (addr_valid !== 1'b0 || addr_out !== '0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_abort: valid=%b addr=%0d done=%b busy=%b required 0/0/0/0",
               addr_valid, addr_out, done, busy);
    end
    @(negedge clk);
    checks++;
    if (addr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL clr_start_dropped: valid=%b busy=%b done=%b required 0/0/0",
               addr_valid, busy, done);
    end
  endtask

  task automatic test_rst_mid();
    std_cfg();
    sb.push_back(21'd100); zq.push_back(1'b0);
    do_start(1'b0);
    drain(1'b0);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (addr_out !== '0 || addr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: addr=%0d valid=%b busy=%b done=%b required all 0",
               addr_out, addr_valid, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || addr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_done: done=%b valid=%b required 0/0", done, addr_valid);
    end
    std_cfg();
    model(1'b0, 1);
    do_start(1'b0);
    drain(1'b1);
  endtask

  task automatic test_wrap();
    load(21'h1FFFFF, 8'd1, 8'd0, 8'd0, 21'd1, 21'd0, 21'd0, 21'd0);
    sb.push_back(21'd2097151); zq.push_back(1'b0);
    sb.push_back(21'd0);       zq.push_back(1'b0);
    do_start(1'b0);
    drain(1'b1);
  endtask

  task automatic test_single();
    load(21'd777, 8'd0, 8'd0, 8'd0, 21'd5, 21'd6, 21'd7, 21'd8);
    sb.push_back(21'd777); zq.push_back(1'b0);
    do_start(1'b0);
    drain(1'b1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      load(21'($urandom), 8'($urandom_range(0, 2)), 8'($urandom_range(0, 2)),
           8'($urandom_range(0, 2)), 21'($urandom), 21'($urandom),
           21'($urandom), 21'($urandom));
      model(t[0], 1 + t[0]);
      do_start(t[0]);
      drain(!t[0]);
      if (t[0]) begin
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_continuous();
    test_backpressure();
    test_clr();
    test_rst_mid();
    test_wrap();
    test_single();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/agu_ndim.md
AGU_NDIM -- requirements
Module: agu_ndim

Interface
REQ-001 SHALL have parameter BWADDR, default 21, address bitwidth.
REQ-002 SHALL have parameter BWLENGTH, default 8, per-level length-counter bitwidth.
REQ-003 SHALL have parameter NDIM, default 3, number of nested loop levels (legal range 1..8).
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clr  input  1  synchronous abort/clear.
REQ-007 SHALL have port start  input  1  begin a sequence; config sampled this cycle.
REQ-008 SHALL have port cont  input  1  continuous (wrap) mode select, sampled with start.
REQ-009 SHALL have port base  input  BWADDR  first address of sequence.
REQ-010 SHALL have port lens  input  NDIM*BWLENGTH  level k length l[k] at bits [k*BWLENGTH +: BWLENGTH]; iterations at level k = l[k]+1.
REQ-011 SHALL have port jumps  input  (NDIM+1)*BWADDR  jump j[k] at bits [k*BWADDR +: BWADDR], k=0..NDIM; j[NDIM] is the wrap jump.
REQ-012 SHALL have port addr_ready  input  1  consumer accepts addr_out.
REQ-013 SHALL have port addr_out  output  BWADDR  current address (registered).
REQ-014 SHALL have port addr_valid  output  1  addr_out valid (registered).
REQ-015 SHALL have port busy  output  1  high in RUN state.
REQ-016 SHALL have port done  output  1  one-cycle pulse after last address of a one-shot sequence is accepted.
REQ-017 SHALL have port zigzag_step  output  1  level-0 wrap indicator (see Configuration).

Function
REQ-018 SHALL implement FSM states IDLE and RUN; fire = addr_valid && addr_ready.
REQ-019 SHALL, in IDLE on start, latch cont/lens/jumps, set addr_out=base, counters i[k]=l[k] for all k, addr_valid=1, enter RUN next cycle (first address visible 1 cycle after start).
REQ-020 SHALL ignore start while in RUN; config inputs are don't-care outside the start cycle.
REQ-021 SHALL hold addr_out, addr_valid and all counters stable while addr_valid && !addr_ready.
REQ-022 SHALL, on fire, select lowest level k with i[k]!=0: addr_out += j[k], i[k] -= 1, i[m]=l[m] for all m<k.
REQ-023 SHALL, on fire with all i[k]==0 and cont=0, drop addr_valid, pulse done for 1 cycle, return to IDLE.
REQ-024 SHALL, on fire with all i[k]==0 and cont=1, apply addr_out += j[NDIM], reload all i[k]=l[k], stay in RUN (no done).
REQ-025 SHALL perform all address arithmetic modulo 2^BWADDR (silent wrap, no flag); jumps are unsigned addends (two's-complement wrap gives negative strides).
REQ-026 SHALL sustain one address per cycle with addr_ready held high.
REQ-027 SHALL give clr priority over start and fire: next cycle IDLE, addr_valid=0, addr_out=0, counters 0, done=0; start in same cycle as clr is dropped.
REQ-028 SHALL, with all l[k]=0 and cont=0, emit exactly one address (base) then done.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force IDLE, addr_out=0, addr_valid=0, busy=0, done=0, zigzag_step=0, all counters and latched config 0.
REQ-030 SHALL, on rst_n assertion mid-sequence, discard the sequence with no done pulse; first start after deassertion behaves as from power-up.

Configuration
REQ-031 SHALL, with macro AGU_ZIGZAG_EN defined, drive zigzag_step = fire && i[0]==0 && (some i[k]!=0 for k>=1, or cont=1) (combinational, same cycle as the fire causing a level >=1 jump).
REQ-032 SHALL, without AGU_ZIGZAG_EN, tie zigzag_step to 0 and synthesise no logic for it.

Verification
REQ-033 SHALL cover one-shot: NDIM=3, base=100, l=(1,1,0), j=(1,10,50,1000), ready=1 -> addr 100,101,111,112 on consecutive cycles, done pulses the cycle after 112 accepted, then IDLE.
REQ-034 SHALL cover continuous: same as REQ-033 with cont=1 -> 100,101,111,112,1112,1113,1123,1124,..., done never asserts.
REQ-035 SHALL cover backpressure: addr_ready low 3 cycles while addr_out=101 -> 101 held stable with addr_valid=1, sequence resumes unchanged.
REQ-036 SHALL cover clr and rst_n mid-sequence: clr at addr 111 -> next cycle addr_valid=0, addr_out=0, no done; rst_n low at addr 101 -> immediate outputs 0; restart yields 100 again.
REQ-037 SHALL cover wrap: base=2^21-1, l=(1,0,0), j0=1 -> 2097151 then 0, then done.
REQ-038 SHALL cover zigzag: REQ-033 stimulus with AGU_ZIGZAG_EN -> zigzag_step high only on the fire of 101; without macro constant 0.
